axis_sample_packer: RTL and testbench

- Sits directly downstream of the ADC data receiver in the ACLK domain.
- Consumes its 16-bit AXI-Stream sample packets and packs N consecutive samples into one wide word for the DMA S2MM port.
- Carries TLAST through to the output. A short final word is padded and marked with TKEEP.
- Exposes per-packet status counters for the control register block.

---
 rtl/axis_sample_packer.sv | 116 +++++++++++
 tb/tb_axis_sample_packer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_packer.sv
// Packs N_PACK consecutive 16-bit AXI-Stream samples into one wide word, carrying
// TLAST through, padding a short final word via TKEEP, and keeping per-packet counters.
module axis_sample_packer #(
    parameter int N_PACK = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [15:0]           s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [16*N_PACK-1:0]  m_axis_tdata,
    output logic [2*N_PACK-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [31:0]           pkt_count,
    output logic [31:0]           last_pkt_words,
    output logic                  pkt_done
);

    generate
        if (N_PACK != 2 && N_PACK != 4) begin : g_bad_n_pack
            $fatal(1, "axis_sample_packer: N_PACK must be 2 or 4");
        end
    endgenerate

    localparam int LW = (N_PACK > 2) ? 2 : 1;

    logic [LW-1:0]         r_lane;
    logic [16*N_PACK-1:0]  r_acc;
    logic [31:0]           r_words;

    logic [31:0]           w_lane_u;
    logic [16*N_PACK-1:0]  w_merged;
    logic [2*N_PACK-1:0]   w_keep;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_hs;

    // Ready is held low during reset so nothing is accepted before the registers settle.
    assign s_axis_tready = ARESETN && enable && (!m_axis_tvalid || m_axis_tready);
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_complete    = w_accept && ((r_lane == LW'(N_PACK - 1)) || s_axis_tlast);
    assign w_hs          = m_axis_tvalid && m_axis_tready;
    assign w_lane_u      = 32'(r_lane);

    always_comb begin
        w_merged = '0;
        w_keep   = '0;
        for (int unsigned i = 0; i < N_PACK; i++) begin
            if (i < w_lane_u) begin
                w_merged[i*16 +: 16] = r_acc[i*16 +: 16];
            end else if (i == w_lane_u) begin
                w_merged[i*16 +: 16] = s_axis_tdata;
            end
            if (i <= w_lane_u) begin
                w_keep[i*2 +: 2] = 2'b11;
            end
        end
    end

    // The merged word doubles as the next accumulator value on non-completing accepts.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_lane <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_lane <= '0;
                r_acc  <= '0;
            end else begin
                r_lane <= r_lane + 1'b1;
                r_acc  <= w_merged;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (w_complete) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= w_merged;
            m_axis_tkeep  <= w_keep;
            m_axis_tlast  <= s_axis_tlast;
        end else if (w_hs) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_words        <= '0;
            pkt_count      <= '0;
            last_pkt_words <= '0;
            pkt_done       <= 1'b0;
        end else begin
            pkt_done <= w_hs && m_axis_tlast;
            if (w_hs) begin
                if (m_axis_tlast) begin
                    pkt_count      <= pkt_count + 32'd1;
                    last_pkt_words <= r_words + 32'd1;
                    r_words        <= '0;
                end else begin
                    r_words <= r_words + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_sample_packer.sv
// Directed bench for axis_sample_packer (N_PACK=2 and N_PACK=4 instances) with
// a reference packing model feeding an expected-word queue.
module tb_axis_sample_packer;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;

    logic        en2 = 1'b1, sv2 = 1'b0, sr2, sl2 = 1'b0, mv2, mr2 = 1'b1, ml2, pd2;
    logic [15:0] sd2 = '0;
    logic [31:0] md2, pc2, lw2;
    logic [3:0]  mk2;

    logic        en4 = 1'b1, sv4 = 1'b0, sr4, sl4 = 1'b0, mv4, mr4 = 1'b1, ml4, pd4;
    logic [15:0] sd4 = '0;
    logic [63:0] md4;
    logic [31:0] pc4, lw4;
    logic [7:0]  mk4;

    int          total = 0;
    int          bad = 0;
    int          pulses2 = 0, pulses4 = 0, stall4 = 0;
    bit          bp_en = 1'b0;

    logic [72:0] q2[$];
    logic [72:0] q4[$];
    logic [31:0] m2_acc = '0;
    logic [63:0] m4_acc = '0;
    int unsigned m2_lane = 0, m4_lane = 0;

    always #5 ACLK = ~ACLK;

    axis_sample_packer #(.N_PACK(2)) dut2 (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(en2),
        .s_axis_tvalid(sv2), .s_axis_tready(sr2), .s_axis_tdata(sd2), .s_axis_tlast(sl2),
        .m_axis_tvalid(mv2), .m_axis_tready(mr2), .m_axis_tdata(md2), .m_axis_tkeep(mk2),
        .m_axis_tlast(ml2), .pkt_count(pc2), .last_pkt_words(lw2), .pkt_done(pd2)
    );

    axis_sample_packer #(.N_PACK(4)) dut4 (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(en4),
        .s_axis_tvalid(sv4), .s_axis_tready(sr4), .s_axis_tdata(sd4), .s_axis_tlast(sl4),
        .m_axis_tvalid(mv4), .m_axis_tready(mr4), .m_axis_tdata(md4), .m_axis_tkeep(mk4),
        .m_axis_tlast(ml4), .pkt_count(pc4), .last_pkt_words(lw4), .pkt_done(pd4)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send2(input logic [15:0] d, input logic l);
        int unsigned n = 0;
        logic ok = 1'b0;
        logic [3:0] k;
        sv2 = 1'b1; sd2 = d; sl2 = l;
        while (!ok && n < 200) begin
            @(negedge ACLK);
            if (sr2) ok = 1'b1; else n++;
        end
        if (!ok) begin
            chk("send2_timeout", {127'h0, ok}, 128'h1);
            sv2 = 1'b0;
            return;
        end
        @(posedge ACLK); #1;
        sv2 = 1'b0;
        m2_acc[m2_lane*16 +: 16] = d;
        if (m2_lane == 1 || l) begin
            k = 4'((1 << (2 * (m2_lane + 1))) - 1);
            q2.push_back({32'h0, m2_acc, 4'h0, k, l});
            m2_acc = '0; m2_lane = 0;
        end else begin
            m2_lane++;
        end
    endtask

    task automatic send4(input logic [15:0] d, input logic l);
        int unsigned n = 0;
        logic ok = 1'b0;
        logic [7:0] k;
        sv4 = 1'b1; sd4 = d; sl4 = l;
        while (!ok && n < 200) begin
            @(negedge ACLK);
            if (sr4) ok = 1'b1; else begin n++; stall4++; end
        end
        if (!ok) begin
            chk("send4_timeout", {127'h0, ok}, 128'h1);
            sv4 = 1'b0;
            return;
        end
        @(posedge ACLK); #1;
        sv4 = 1'b0;
        m4_acc[m4_lane*16 +: 16] = d;
        if (m4_lane == 3 || l) begin
            k = 8'((1 << (2 * (m4_lane + 1))) - 1);
            q4.push_back({m4_acc, k, l});
            m4_acc = '0; m4_lane = 0;
        end else begin
            m4_lane++;
        end
    endtask

    task automatic drain(input int which);
        int unsigned n = 0;
        while (((which == 2) ? q2.size() : q4.size()) != 0 && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        chk((which == 2) ? "drain2" : "drain4",
            128'((which == 2) ? q2.size() : q4.size()), 128'h0);
        repeat (3) @(posedge ACLK);
        #1;
    endtask

    initial begin
        logic any_ready;
        logic [15:0] v;

        fork
            forever begin
                @(negedge ACLK);
                if (ARESETN) begin
                    if (pd2) pulses2++;
                    if (pd4) pulses4++;
                    if (mv2 && mr2) begin
                        if (q2.size() == 0) chk("unexpected_word2", {55'h0, 32'h0, md2, 4'h0, mk2, ml2}, 128'h0);
                        else chk("word2", {55'h0, 32'h0, md2, 4'h0, mk2, ml2}, {55'h0, q2.pop_front()});
                    end
                    if (mv4 && mr4) begin
                        if (q4.size() == 0) chk("unexpected_word4", {55'h0, md4, mk4, ml4}, 128'h0);
                        else chk("word4", {55'h0, md4, mk4, ml4}, {55'h0, q4.pop_front()});
                    end
                end
            end
            forever begin
                @(posedge ACLK); #1;
                if (bp_en) mr2 = ($urandom_range(0, 3) != 0);
            end
        join_none

        // Reset state, with enable high so ready must still be low.
        repeat (2) @(negedge ACLK);
        chk("reset2", {sr2, mv2, md2, mk2, ml2, pc2, lw2, pd2}, '0);
        chk("reset4", {sr4, mv4, md4, mk4, ml4, pc4, lw4, pd4}, '0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Basic 4-sample packet, TLAST on the 4th.
        for (int i = 1; i <= 4; i++) send2(16'(i), i == 4);
        drain(2);
        chk("t1_pkt_count", pc2, 1);
        chk("t1_last_words", lw2, 2);
        chk("t1_pulses", pulses2, 1);

        // Short final word: 3 samples.
        for (int i = 1; i <= 3; i++) send2(16'(i), i == 3);
        drain(2);
        chk("t2_pkt_count", pc2, 2);
        chk("t2_last_words", lw2, 2);
        chk("t2_pulses", pulses2, 2);

        // N_PACK=4 continuous stream.
        stall4 = 0;
        for (int i = 0; i < 8; i++) send4(16'h0010 + 16'(i), i == 7);
        chk("t3_no_stall", stall4, 0);
        drain(4);
        chk("t3_pkt_count", pc4, 1);
        chk("t3_last_words", lw4, 2);
        chk("t3_pulses", pulses4, 1);

        // Backpressure: pending word held for 5 cycles, then a randomly throttled 64-sample packet.
        mr2 = 1'b0;
        send2(16'h0B00, 1'b0);
        send2(16'h0B01, 1'b0);
        sv2 = 1'b1; sd2 = 16'h0B02; sl2 = 1'b0;
        repeat (5) begin
            @(negedge ACLK);
            chk("bp_hold", {sr2, mv2, md2, mk2, ml2}, {1'b0, 1'b1, 32'h0B010B00, 4'hF, 1'b0});
        end
        @(posedge ACLK); #1;
        mr2 = 1'b1;
        send2(16'h0B02, 1'b0);
        bp_en = 1'b1;
        for (int i = 3; i < 64; i++) begin
            v = 16'($urandom);
            send2(v, i == 63);
        end
        bp_en = 1'b0;
        mr2 = 1'b1;
        drain(2);
        chk("t4_pkt_count", pc2, 3);
        chk("t4_last_words", lw2, 32);
        chk("t4_pulses", pulses2, 3);

        // enable low mid-word for 10 cycles.
        send2(16'h00AA, 1'b0);
        en2 = 1'b0;
        sv2 = 1'b1; sd2 = 16'h00BB; sl2 = 1'b1;
        any_ready = 1'b0;
        repeat (10) begin
            @(negedge ACLK);
            if (sr2 || mv2) any_ready = 1'b1;
        end
        chk("t5_stalled", {127'h0, any_ready}, 128'h0);
        @(posedge ACLK); #1;
        en2 = 1'b1;
        send2(16'h00BB, 1'b1);
        drain(2);
        chk("t5_pkt_count", pc2, 4);
        chk("t5_last_words", lw2, 1);

        // Reset in the middle of a packet discards the partial word.
        for (int i = 1; i <= 3; i++) send2(16'h0011 * 16'(i), 1'b0);
        drain(2);
        ARESETN = 1'b0;
        @(negedge ACLK);
        chk("t6_in_reset", {sr2, mv2, md2, mk2, ml2, pc2, lw2, pd2}, '0);
        q2.delete(); m2_acc = '0; m2_lane = 0;
        q4.delete(); m4_acc = '0; m4_lane = 0;
        pulses2 = 0; pulses4 = 0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        send2(16'h0101, 1'b0);
        send2(16'h0202, 1'b1);
        drain(2);
        chk("t6_pkt_count", pc2, 1);
        chk("t6_last_words", lw2, 1);
        chk("t6_pulses", pulses2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        chk("global_timeout", 128'h1, {127'h0, ARESETN === 1'bx});
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "FAIL global_timeout");
    end

endmodule
